// File: rtl/stack_ctrl.sv
// LIFO operand stack controller driving a single-port synchronous RAM (write on rise, read data registered on fall).
// Optional high-water-mark output enabled by defining STACK_CTRL_WATERMARK_EN.
module stack_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  cmd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  err_overflow,
  output logic                  err_underflow,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_we,
  output logic                  mem_re,
`ifdef STACK_CTRL_WATERMARK_EN
  output logic [ADDR_WIDTH:0]   high_water,
`endif
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam logic [1:0] OP_PUSH  = 2'b00;
  localparam logic [1:0] OP_POP   = 2'b01;
  localparam logic [1:0] OP_PEEK  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t                r_state;
  logic                  r_cmd_ready;
  logic                  r_is_pop;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  r_err_ovf;
  logic                  r_err_unf;
  logic [ADDR_WIDTH-1:0] r_mem_address;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_mem_we;
  logic                  r_mem_re;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_accept;

  assign w_full   = (r_count == DEPTH_C);
  assign w_empty  = (r_count == '0);
  assign w_accept = cmd_valid && r_cmd_ready;

  // Single FSM: every output, including the RAM strobes, is a register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cmd_ready   <= 1'b1;
      r_is_pop      <= 1'b0;
      r_count       <= '0;
      r_rd_data     <= '0;
      r_rd_valid    <= 1'b0;
      r_err_ovf     <= 1'b0;
      r_err_unf     <= 1'b0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_mem_we      <= 1'b0;
      r_mem_re      <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            case (cmd_op)
              OP_PUSH: begin
                if (w_full) begin
                  r_err_ovf <= 1'b1;
                end else begin
                  r_mem_address <= r_count[ADDR_WIDTH-1:0];
                  r_mem_data    <= cmd_data;
                  r_mem_we      <= 1'b1;
                  r_cmd_ready   <= 1'b0;
                  r_state       <= WRITE;
                end
              end
              OP_POP, OP_PEEK: begin
                if (w_empty) begin
                  r_err_unf <= 1'b1;
                end else begin
                  r_mem_address <= r_count[ADDR_WIDTH-1:0] - 1'b1;
                  r_mem_re      <= 1'b1;
                  r_is_pop      <= (cmd_op == OP_POP);
                  r_cmd_ready   <= 1'b0;
                  r_state       <= READ;
                end
              end
              default: begin
                r_count   <= '0;
                r_err_ovf <= 1'b0;
                r_err_unf <= 1'b0;
              end
            endcase
          end
        end
        WRITE: begin
          r_mem_we    <= 1'b0;
          r_count     <= r_count + 1'b1;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        READ: begin
          // RAM captured the word on the falling edge inside this cycle.
          r_rd_data   <= mem_data_out;
          r_rd_valid  <= 1'b1;
          r_mem_re    <= 1'b0;
          if (r_is_pop) r_count <= r_count - 1'b1;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_mem_we    <= 1'b0;
          r_mem_re    <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

`ifdef STACK_CTRL_WATERMARK_EN
  logic [ADDR_WIDTH:0] r_high_water;
  logic                w_clear_acc;

  assign w_clear_acc = w_accept && (cmd_op == OP_CLEAR);

  // Tracks the count one cycle late; clear restarts the mark from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_high_water <= '0;
    end else if (w_clear_acc) begin
      r_high_water <= '0;
    end else if (r_count > r_high_water) begin
      r_high_water <= r_count;
    end
  end

  assign high_water = r_high_water;
`endif

  assign cmd_ready     = r_cmd_ready;
  assign rd_data       = r_rd_data;
  assign rd_valid      = r_rd_valid;
  assign count         = r_count;
  assign full          = w_full;
  assign empty         = w_empty;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;
  assign mem_address   = r_mem_address;
  assign mem_data      = r_mem_data;
  assign mem_we        = r_mem_we;
  assign mem_re        = r_mem_re;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios plus random commands against a queue-based stack model and a behavioural RAM.
module tb_stack_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic [DW-1:0] cmd_data = '0;
  logic          cmd_ready;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          full, empty, err_overflow, err_underflow;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data;
  logic          mem_we, mem_re;
  logic [DW-1:0] mem_data_out = '0;
`ifdef STACK_CTRL_WATERMARK_EN
  logic [AW:0]   high_water;
`endif

  stack_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .full(full), .empty(empty), .err_overflow(err_overflow), .err_underflow(err_underflow),
    .mem_address(mem_address), .mem_data(mem_data), .mem_we(mem_we), .mem_re(mem_re),
`ifdef STACK_CTRL_WATERMARK_EN
    .high_water(high_water),
`endif
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM: write on rising edge, read data registered on falling edge.
  logic [DW-1:0] ram [DEPTH];
  always @(posedge clk) if (mem_we) ram[mem_address] <= mem_data;
  always @(negedge clk) if (mem_re) mem_data_out <= ram[mem_address];

  int checks = 0;
  int errors = 0;

  // Stack reference model
  logic [DW-1:0] m_q[$];
  logic          m_ovf = 1'b0, m_unf = 1'b0;
  logic [DW-1:0] m_rd = '0;
  int            m_hw = 0;
  int            e_we, e_re, e_rv, e_busy;
  logic [AW-1:0] e_addr;

  // Observations of one command window
  int            o_we, o_re, o_rv, o_rvn, o_busy, o_both;
  logic [AW-1:0] o_addr;

  task automatic model_reset();
    m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_rd = '0; m_hw = 0;
  endtask

  task automatic model_cmd(input logic [1:0] op, input logic [DW-1:0] d);
    e_we = 0; e_re = 0; e_rv = 0; e_busy = 0; e_addr = '0;
    case (op)
      2'b00: if (m_q.size() == DEPTH) m_ovf = 1'b1;
             else begin e_addr = AW'(m_q.size()); e_we = 1; e_busy = 1; m_q.push_back(d); end
      2'b01, 2'b10: if (m_q.size() == 0) m_unf = 1'b1;
             else begin
               e_addr = AW'(m_q.size() - 1); e_re = 1; e_busy = 1; e_rv = 2;
               if (op == 2'b01) m_rd = m_q.pop_back(); else m_rd = m_q[$];
             end
      default: begin m_q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_hw = 0; end
    endcase
    if (m_q.size() > m_hw) m_hw = m_q.size();
  endtask

  task automatic apply_reset();
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Issue one command for a single cycle, then watch four cycles of the interface.
  task automatic do_cmd(input logic [1:0] op, input logic [DW-1:0] d);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = $urandom;
    o_we = 0; o_re = 0; o_rv = 0; o_rvn = 0; o_busy = 0; o_both = 0; o_addr = '0;
    for (int k = 1; k <= 4; k++) begin
      if (mem_we) begin o_we++; o_addr = mem_address; end
      if (mem_re) begin o_re++; o_addr = mem_address; end
      if (mem_we && mem_re) o_both++;
      if (rd_valid) begin o_rvn++; o_rv = k; end
      if (!cmd_ready) o_busy++;
      if (k < 4) begin @(posedge clk); #1; end
    end
    model_cmd(op, d);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({cmd_ready, mem_we, mem_re, rd_valid, err_overflow, err_underflow, empty, full} !== 8'b1000_0010) begin
      errors++; $display("FAIL reset_ctrl got %b want 10000010",
        {cmd_ready, mem_we, mem_re, rd_valid, err_overflow, err_underflow, empty, full});
    end
    checks++;
    if (count !== '0 || mem_address !== '0 || mem_data !== '0 || rd_data !== '0) begin
      errors++; $display("FAIL reset_data got cnt=%0d addr=%0d wd=%0h rd=%0h want all 0", count, mem_address, mem_data, rd_data);
    end
`ifdef STACK_CTRL_WATERMARK_EN
    checks++;
    if (high_water !== '0) begin errors++; $display("FAIL reset_hw got %0d want 0", high_water); end
`endif
  endtask

  task automatic test_push_pop();
    logic [DW-1:0] vals [3];
    logic [DW-1:0] pops [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      do_cmd(2'b00, vals[i]);
      checks++;
      if (o_we !== 1 || o_re !== 0 || o_addr !== AW'(i) || o_busy !== 1) begin
        errors++; $display("FAIL push%0d got we=%0d re=%0d addr=%0d busy=%0d want 1 0 %0d 1", i, o_we, o_re, o_addr, o_busy, i);
      end
    end
    checks++;
    if (count !== 3'd3) begin errors++; $display("FAIL push_count got %0d want 3", count); end
    pops[0] = 32'h33; pops[1] = 32'h22;
    for (int i = 0; i < 2; i++) begin
      do_cmd(2'b01, '0);
      checks++;
      if (rd_data !== pops[i] || o_rv !== 2 || o_rvn !== 1 || o_re !== 1) begin
        errors++; $display("FAIL pop%0d got rd=%0h rv_at=%0d rv_n=%0d re=%0d want %0h 2 1 1", i, rd_data, o_rv, o_rvn, o_re, pops[i]);
      end
    end
    do_cmd(2'b10, '0);
    checks++;
    if (rd_data !== 32'h11 || count !== 3'd1 || o_rv !== 2) begin
      errors++; $display("FAIL peek got rd=%0h cnt=%0d rv_at=%0d want 11 1 2", rd_data, count, o_rv);
    end
    do_cmd(2'b01, '0);
    checks++;
    if (rd_data !== 32'h11 || count !== 3'd0 || err_underflow !== 1'b0) begin
      errors++; $display("FAIL pop_last got rd=%0h cnt=%0d unf=%b want 11 0 0", rd_data, count, err_underflow);
    end
    for (int i = 0; i < 2; i++) begin
      do_cmd(2'b01, '0);
      checks++;
      if (err_underflow !== 1'b1 || o_re !== 0 || o_rvn !== 0 || o_busy !== 0 || rd_data !== 32'h11) begin
        errors++; $display("FAIL underflow%0d got unf=%b re=%0d rv=%0d busy=%0d rd=%0h want 1 0 0 0 11",
          i, err_underflow, o_re, o_rvn, o_busy, rd_data);
      end
    end
  endtask

  task automatic test_overflow();
    do_cmd(2'b11, '0);
    do_cmd(2'b01, '0);
    for (int i = 0; i < 5; i++) begin
      do_cmd(2'b00, 32'hA0 + DW'(i));
      if (i == 3) begin
        checks++;
        if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL full got full=%b cnt=%0d want 1 4", full, count); end
      end
    end
    checks++;
    if (err_overflow !== 1'b1 || o_we !== 0 || count !== 3'd4 || o_busy !== 0) begin
      errors++; $display("FAIL overflow got ovf=%b we=%0d cnt=%0d busy=%0d want 1 0 4 0", err_overflow, o_we, count, o_busy);
    end
    do_cmd(2'b01, '0);
    checks++;
    if (rd_data !== 32'hA3) begin errors++; $display("FAIL pop_after_ovf got %0h want a3", rd_data); end
    do_cmd(2'b00, 32'hA3);
  endtask

  task automatic test_clear();
    checks++;
    if (count !== 3'd4 || err_overflow !== 1'b1 || err_underflow !== 1'b1) begin
      errors++; $display("FAIL clear_pre got cnt=%0d ovf=%b unf=%b want 4 1 1", count, err_overflow, err_underflow);
    end
    do_cmd(2'b11, '0);
    checks++;
    if (count !== '0 || empty !== 1'b1 || err_overflow !== 1'b0 || err_underflow !== 1'b0 || o_we !== 0 || o_re !== 0 || o_busy !== 0) begin
      errors++; $display("FAIL clear got cnt=%0d empty=%b ovf=%b unf=%b we=%0d re=%0d busy=%0d want 0 1 0 0 0 0 0",
        count, empty, err_overflow, err_underflow, o_we, o_re, o_busy);
    end
    do_cmd(2'b01, '0);
    checks++;
    if (err_underflow !== 1'b1 || o_re !== 0) begin errors++; $display("FAIL clear_then_pop got unf=%b re=%0d want 1 0", err_underflow, o_re); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] b1, b2;
    b1 = $urandom; b2 = $urandom;
    do_cmd(2'b11, '0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = b1;
    @(posedge clk); #1;
    cmd_data = b2;
    checks++;
    if (mem_we !== 1'b1 || mem_address !== 2'd0 || cmd_ready !== 1'b0) begin
      errors++; $display("FAIL b2b_first got we=%b addr=%0d rdy=%b want 1 0 0", mem_we, mem_address, cmd_ready);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (mem_we !== 1'b1 || mem_address !== 2'd1 || mem_data !== b2) begin
      errors++; $display("FAIL b2b_second got we=%b addr=%0d wd=%0h want 1 1 %0h", mem_we, mem_address, mem_data, b2);
    end
    repeat (2) @(posedge clk);
    model_cmd(2'b00, b1);
    model_cmd(2'b00, b2);
    do_cmd(2'b01, '0);
    do_cmd(2'b01, '0);
    checks++;
    if (rd_data !== b1 || count !== '0) begin errors++; $display("FAIL b2b_data got rd=%0h cnt=%0d want %0h 0", rd_data, count, b1); end
  endtask

  task automatic test_reset_mid_read();
    do_cmd(2'b00, 32'h5A5A);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b01;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    checks++;
    if (mem_re !== 1'b1) begin errors++; $display("FAIL midread_re got %b want 1", mem_re); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_re !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL async_abort got re=%b we=%b want 0 0", mem_re, mem_we); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    checks++;
    if (count !== '0 || cmd_ready !== 1'b1 || rd_valid !== 1'b0 || mem_re !== 1'b0) begin
      errors++; $display("FAIL after_abort got cnt=%0d rdy=%b rv=%b re=%b want 0 1 0 0", count, cmd_ready, rd_valid, mem_re);
    end
  endtask

`ifdef STACK_CTRL_WATERMARK_EN
  task automatic test_watermark();
    do_cmd(2'b11, '0);
    for (int i = 0; i < 3; i++) do_cmd(2'b00, $urandom);
    do_cmd(2'b01, '0);
    do_cmd(2'b01, '0);
    checks++;
    if (high_water !== 3'd3 || count !== 3'd1) begin errors++; $display("FAIL watermark got hw=%0d cnt=%0d want 3 1", high_water, count); end
    do_cmd(2'b11, '0);
    checks++;
    if (high_water !== '0) begin errors++; $display("FAIL watermark_clear got %0d want 0", high_water); end
  endtask
`endif

  task automatic test_random();
    int r;
    logic [1:0] op;
    for (int n = 0; n < 200; n++) begin
      r = $urandom_range(0, 19);
      op = (r < 9) ? 2'b00 : (r < 14) ? 2'b01 : (r < 18) ? 2'b10 : 2'b11;
      do_cmd(op, $urandom);
      checks++;
      if (o_we !== e_we || o_re !== e_re || o_both !== 0 || o_addr !== e_addr || o_busy !== e_busy) begin
        errors++; $display("FAIL rnd_ram n=%0d op=%0d got we=%0d re=%0d both=%0d addr=%0d busy=%0d want %0d %0d 0 %0d %0d",
          n, op, o_we, o_re, o_both, o_addr, o_busy, e_we, e_re, e_addr, e_busy);
      end
      checks++;
      if (o_rv !== e_rv || o_rvn !== ((e_rv != 0) ? 1 : 0) || rd_data !== m_rd) begin
        errors++; $display("FAIL rnd_read n=%0d got rv_at=%0d rv_n=%0d rd=%0h want %0d %0h", n, o_rv, o_rvn, rd_data, e_rv, m_rd);
      end
      checks++;
      if (count !== (AW+1)'(m_q.size()) || full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0)
          || err_overflow !== m_ovf || err_underflow !== m_unf) begin
        errors++; $display("FAIL rnd_state n=%0d got cnt=%0d f=%b e=%b ovf=%b unf=%b want cnt=%0d ovf=%b unf=%b",
          n, count, full, empty, err_overflow, err_underflow, m_q.size(), m_ovf, m_unf);
      end
`ifdef STACK_CTRL_WATERMARK_EN
      checks++;
      if (high_water !== (AW+1)'(m_hw)) begin errors++; $display("FAIL rnd_hw n=%0d got %0d want %0d", n, high_water, m_hw); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_clear();
    test_back_to_back();
    test_reset_mid_read();
`ifdef STACK_CTRL_WATERMARK_EN
    test_watermark();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Initiator-side controller that drives the team's single-port synchronous RAM interface: address, write data, write enable, read enable, and read data back.
- Presents a LIFO operand stack (push/pop/peek/clear) to the calculator datapath through a valid/ready command handshake.
- Sequences RAM accesses to match the RAM's timing: the RAM writes on the clk rising edge and registers read data on the clk falling edge.

Parameters:
- DATA_WIDTH, 32, width of stack entries and RAM data.
- ADDR_WIDTH, 8, RAM address width.
- DEPTH, 1<<ADDR_WIDTH, number of stack entries; equals the RAM depth.

Ports:
- clk  in  1  system clock; all state is updated on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_op  in  2  command: 00 push, 01 pop, 10 peek, 11 clear.
- cmd_data  in  DATA_WIDTH  push operand.
- cmd_ready  out  1  high only in IDLE; a command is accepted when cmd_valid && cmd_ready at a rising edge.
- rd_data  out  DATA_WIDTH  result of pop or peek; holds its value until the next pop or peek.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.
- count  out  ADDR_WIDTH+1  current number of entries.
- full  out  1  count==DEPTH.
- empty  out  1  count==0.
- err_overflow  out  1  sticky; set by a push while full.
- err_underflow  out  1  sticky; set by a pop or peek while empty.
- mem_address  out  ADDR_WIDTH  RAM address.
- mem_data  out  DATA_WIDTH  RAM write data.
- mem_we  out  1  RAM write enable.
- mem_re  out  1  RAM read enable.
- mem_data_out  in  DATA_WIDTH  RAM read data.

Behaviour:
- Reset (asynchronous, active-low):
  - State is IDLE; count=0.
  - mem_we=0, mem_re=0, mem_address=0, mem_data=0.
  - rd_data=0, rd_valid=0, both error flags 0.
  - cmd_ready=1 after reset.
  - RAM contents are not touched.
- All RAM interface outputs are registered.
- States are IDLE, WRITE, READ.
- Push accepted in IDLE, not full:
  - mem_address<=count[ADDR_WIDTH-1:0], mem_data<=cmd_data, mem_we<=1; go to WRITE.
  - WRITE (1 cycle): the RAM commits at this cycle's closing edge. Then mem_we<=0, count<=count+1, go to IDLE.
  - Push latency is 2 cycles from acceptance to cmd_ready high again.
- Pop or peek accepted in IDLE, not empty:
  - mem_address<=count-1, mem_re<=1; go to READ.
  - READ (1 cycle): the RAM registers its output on the falling edge. At the closing rising edge: rd_data<=mem_data_out, rd_valid<=1, mem_re<=0, go to IDLE.
  - Pop also does count<=count-1; peek leaves count unchanged.
  - rd_valid is high in the cycle after READ, i.e. 2 cycles after acceptance.
- Push while full:
  - Accepted in 1 cycle, no RAM access, err_overflow<=1, count unchanged, remain in IDLE.
- Pop or peek while empty:
  - Accepted in 1 cycle, no RAM access, err_underflow<=1, rd_valid stays 0, rd_data unchanged.
- Clear:
  - 1 cycle; count<=0, both error flags <=0, no RAM access.
  - Stale RAM data is not observable, because later pops are guarded by count.
- Error flags clear only on reset or clear.
- mem_we and mem_re are never high together; each is high for exactly one cycle per operation.
- cmd_op and cmd_data are sampled only at acceptance; changes during WRITE or READ are ignored.
- Counter width: count is ADDR_WIDTH+1 bits so that DEPTH is representable. The address is formed from the low ADDR_WIDTH bits; no wrap is possible because pushes are blocked at full.
- Reset asserted during WRITE or READ: the operation is aborted immediately, mem_we and mem_re drop asynchronously, and count returns to 0.
  - If reset arrives after the write edge, the RAM location may hold the new data; that is harmless.

Optional Feature:
- Macro: STACK_CTRL_WATERMARK_EN.
- Defined:
  - Extra output high_water (ADDR_WIDTH+1 bits), reset 0.
  - Updates to max(high_water, count) one cycle after count changes.
  - Cleared by the clear command.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 -> mem_we pulses at addresses 0, 1, 2; count=3; cmd_ready low for exactly 1 cycle after each acceptance.
- Pop, pop -> rd_data 0x33 then 0x22, each with a 1-cycle rd_valid two cycles after acceptance; count=1. Peek -> rd_data=0x11, count stays 1.
- Pop 3 times from count=1 -> the first returns 0x11; the second sets err_underflow with no mem_re and no rd_valid; the third leaves err_underflow at 1.
- With ADDR_WIDTH=2, push 5 values 0xA0..0xA4 -> full after the 4th; the 5th sets err_overflow with no mem_we; count=4; a later pop returns 0xA3.
- Clear with count=4 and both flags set -> one cycle later count=0, empty=1, flags=0, no RAM access; a following pop sets err_underflow.
- Drop rst_n mid-READ -> mem_re=0 immediately; count=0 and cmd_ready=1 after release. With STACK_CTRL_WATERMARK_EN defined: push 3, pop 2 -> high_water=3.
